// File: rtl/serial_frame_rx.sv
// Serial command-frame receiver: start bit, command, address, optional write data,
// optional even parity; presents the last accepted frame on held output registers.
module serial_frame_rx #(
    parameter int               CMD_W     = 3,
    parameter int               ADDR_W    = 6,
    parameter int               DATA_W    = 8,
    parameter logic [CMD_W-1:0] CMD_WR    = 3'b110,
    parameter logic [CMD_W-1:0] CMD_RD    = 3'b101,
    parameter int               PARITY_EN = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_flow,
    input  logic              bit_valid,
    output logic [CMD_W-1:0]  out_cmd,
    output logic [ADDR_W-1:0] out_address,
    output logic [DATA_W-1:0] out_data,
    output logic              ready_r,
    output logic              is_read,
    output logic              busy,
    output logic              err_cmd,
    output logic              err_parity
);
    localparam int MAX_W = (CMD_W > ADDR_W) ? ((CMD_W > DATA_W) ? CMD_W : DATA_W)
                                            : ((ADDR_W > DATA_W) ? ADDR_W : DATA_W);
    localparam int CNT_W = $clog2(MAX_W) + 1;
    localparam logic [CNT_W-1:0] CMD_LAST  = CNT_W'(CMD_W - 1);
    localparam logic [CNT_W-1:0] ADDR_LAST = CNT_W'(ADDR_W - 1);
    localparam logic [CNT_W-1:0] DATA_LAST = CNT_W'(DATA_W - 1);

    typedef enum logic [2:0] {IDLE, CMD, ADDR, DATA, PAR, DONE} state_t;

    state_t              r_state, w_state_next;
    logic [CNT_W-1:0]    r_cnt, w_cnt_next;
    logic [CMD_W-1:0]    r_cmd, w_cmd_next;
    logic [ADDR_W-1:0]   r_addr, w_addr_next;
    logic [DATA_W-1:0]   r_data, w_data_next;
    logic                r_par, w_par_next;
    logic                r_err_cmd, w_err_cmd_next;
    logic                r_err_par, w_err_par_next;
    logic                w_load;
    logic [CMD_W-1:0]    r_out_cmd;
    logic [ADDR_W-1:0]   r_out_addr;
    logic [DATA_W-1:0]   r_out_data;
    logic                r_is_read;
    logic [CMD_W-1:0]    w_cmd_shift;

    assign w_cmd_shift = {r_cmd[CMD_W-2:0], in_flow};

    always_comb begin
        w_state_next   = r_state;
        w_cnt_next     = r_cnt;
        w_cmd_next     = r_cmd;
        w_addr_next    = r_addr;
        w_data_next    = r_data;
        w_par_next     = r_par;
        w_err_cmd_next = 1'b0;
        w_err_par_next = 1'b0;
        w_load         = 1'b0;
        case (r_state)
            IDLE: begin
                if (bit_valid && in_flow) begin
                    w_state_next = CMD;
                    w_cnt_next   = '0;
                    w_par_next   = 1'b0;
                end
            end
            CMD: begin
                if (bit_valid) begin
                    w_cmd_next = w_cmd_shift;
                    w_par_next = r_par ^ in_flow;
                    w_cnt_next = r_cnt + 1'b1;
                    if (r_cnt == CMD_LAST) begin
                        w_cnt_next = '0;
                        if (w_cmd_shift == CMD_WR || w_cmd_shift == CMD_RD) begin
                            w_state_next = ADDR;
                        end else begin
                            w_state_next   = IDLE;
                            w_err_cmd_next = 1'b1;
                        end
                    end
                end
            end
            ADDR: begin
                if (bit_valid) begin
                    w_addr_next = {r_addr[ADDR_W-2:0], in_flow};
                    w_par_next  = r_par ^ in_flow;
                    w_cnt_next  = r_cnt + 1'b1;
                    if (r_cnt == ADDR_LAST) begin
                        w_cnt_next = '0;
                        if (r_cmd == CMD_WR) begin
                            w_state_next = DATA;
                        end else if (PARITY_EN != 0) begin
                            w_state_next = PAR;
                        end else begin
                            w_state_next = DONE;
                            w_load       = 1'b1;
                        end
                    end
                end
            end
            DATA: begin
                if (bit_valid) begin
                    w_data_next = {r_data[DATA_W-2:0], in_flow};
                    w_par_next  = r_par ^ in_flow;
                    w_cnt_next  = r_cnt + 1'b1;
                    if (r_cnt == DATA_LAST) begin
                        w_cnt_next = '0;
                        if (PARITY_EN != 0) begin
                            w_state_next = PAR;
                        end else begin
                            w_state_next = DONE;
                            w_load       = 1'b1;
                        end
                    end
                end
            end
            PAR: begin
                if (bit_valid) begin
                    if ((r_par ^ in_flow) == 1'b0) begin
                        w_state_next = DONE;
                        w_load       = 1'b1;
                    end else begin
                        w_state_next   = IDLE;
                        w_err_par_next = 1'b1;
                    end
                end
            end
            DONE:    w_state_next = IDLE;
            default: w_state_next = IDLE;
        endcase
    end

    // Outputs are captured on the edge that enters DONE so they are valid alongside ready_r.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= IDLE;
            r_cnt      <= '0;
            r_cmd      <= '0;
            r_addr     <= '0;
            r_data     <= '0;
            r_par      <= 1'b0;
            r_err_cmd  <= 1'b0;
            r_err_par  <= 1'b0;
            r_out_cmd  <= '0;
            r_out_addr <= '0;
            r_out_data <= '0;
            r_is_read  <= 1'b0;
        end else begin
            r_state   <= w_state_next;
            r_cnt     <= w_cnt_next;
            r_cmd     <= w_cmd_next;
            r_addr    <= w_addr_next;
            r_data    <= w_data_next;
            r_par     <= w_par_next;
            r_err_cmd <= w_err_cmd_next;
            r_err_par <= w_err_par_next;
            if (w_load) begin
                r_out_cmd  <= w_cmd_next;
                r_out_addr <= w_addr_next;
                r_is_read  <= (w_cmd_next == CMD_RD);
                if (w_cmd_next == CMD_WR) begin
                    r_out_data <= w_data_next;
                end
            end
        end
    end

    assign out_cmd     = r_out_cmd;
    assign out_address = r_out_addr;
    assign out_data    = r_out_data;
    assign is_read     = r_is_read;
    assign ready_r     = (r_state == DONE);
    assign busy        = (r_state != IDLE);
    assign err_cmd     = r_err_cmd;
    assign err_parity  = r_err_par;
endmodule

// File: tb/tb_serial_frame_rx.sv
// Randomised scoreboard bench for serial_frame_rx: a default-parameter instance and a
// wide-data, no-parity instance, both checked against a frame-level reference model.
module tb_serial_frame_rx;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic        in0 = 1'b0, bv0 = 1'b0;
    logic [2:0]  cmd0;
    logic [5:0]  addr0;
    logic [7:0]  data0;
    logic        rdy0, rd0, busy0, ec0, ep0;

    logic        in1 = 1'b0, bv1 = 1'b0;
    logic [2:0]  cmd1;
    logic [3:0]  addr1;
    logic [15:0] data1;
    logic        rdy1, rd1, busy1, ec1, ep1;

    serial_frame_rx u_dut0 (
        .clk(clk), .rst_n(rst_n), .in_flow(in0), .bit_valid(bv0),
        .out_cmd(cmd0), .out_address(addr0), .out_data(data0), .ready_r(rdy0),
        .is_read(rd0), .busy(busy0), .err_cmd(ec0), .err_parity(ep0)
    );

    serial_frame_rx #(.ADDR_W(4), .DATA_W(16), .PARITY_EN(0)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .in_flow(in1), .bit_valid(bv1),
        .out_cmd(cmd1), .out_address(addr1), .out_data(data1), .ready_r(rdy1),
        .is_read(rd1), .busy(busy1), .err_cmd(ec1), .err_parity(ep1)
    );

    typedef struct {
        int kind;   // 0 accepted, 1 bad command, 2 bad parity
        int cyc;
        int cmd;
        int addr;
        int data;
        int rd;
    } exp_t;

    exp_t q0[$];
    exp_t q1[$];
    int   m_cmd[2], m_addr[2], m_data[2], m_rd[2];
    int   total = 0;
    int   bad = 0;

    function automatic void chk(string name, int act, int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endfunction

    task automatic drive(input int inst, input logic v, input logic b);
        if (inst == 0) begin bv0 = v; in0 = b; end
        else begin bv1 = v; in1 = b; end
        @(posedge clk);
        #1;
    endtask

    // Builds the frame from its fields, predicts the outcome, then streams it with random gaps.
    task automatic send(input int inst, input int cmdv, input int addrv, input int datav,
                        input bit flip, input int gap);
        int   aw, dw, kind;
        bit   pe, par, ok;
        bit   bits[$];
        exp_t e;
        aw = (inst == 0) ? 6 : 4;
        dw = (inst == 0) ? 8 : 16;
        pe = (inst == 0);
        addrv = addrv & ((1 << aw) - 1);
        datav = datav & ((1 << dw) - 1);
        ok = (cmdv == 6) || (cmdv == 5);
        bits.push_back(1'b1);
        for (int i = 2; i >= 0; i--) bits.push_back(cmdv[i]);
        if (ok) begin
            for (int i = aw - 1; i >= 0; i--) bits.push_back(addrv[i]);
            if (cmdv == 6) for (int i = dw - 1; i >= 0; i--) bits.push_back(datav[i]);
            if (pe) begin
                par = 1'b0;
                for (int i = 1; i < bits.size(); i++) par ^= bits[i];
                bits.push_back(par ^ flip);
            end
        end
        kind = !ok ? 1 : ((pe && flip) ? 2 : 0);
        if (kind == 0) begin
            m_cmd[inst]  = cmdv;
            m_addr[inst] = addrv;
            if (cmdv == 6) m_data[inst] = datav;
            m_rd[inst]   = (cmdv == 5) ? 1 : 0;
        end
        foreach (bits[i]) begin
            while (gap > 0 && $urandom_range(99) < gap) drive(inst, 1'b0, 1'($urandom));
            drive(inst, 1'b1, bits[i]);
        end
        e.kind = kind; e.cyc = cyc; e.cmd = m_cmd[inst]; e.addr = m_addr[inst];
        e.data = m_data[inst]; e.rd = m_rd[inst];
        if (inst == 0) q0.push_back(e); else q1.push_back(e);
        drive(inst, 1'($urandom), 1'b0);
        drive(inst, 1'b0, 1'b0);
    endtask

    exp_t e0, e1;
    always @(negedge clk) begin
        if (rst_n && (rdy0 || ec0 || ep0)) begin
            chk("excl0", int'(rdy0) + int'(ec0) + int'(ep0), 1);
            if (q0.size() == 0) begin
                chk("unexpected_pulse0", 1, 0);
            end else begin
                e0 = q0.pop_front();
                chk("kind0", rdy0 ? 0 : (ec0 ? 1 : 2), e0.kind);
                chk("latency0", cyc, e0.cyc);
                chk("cmd0", int'(cmd0), e0.cmd);
                chk("addr0", int'(addr0), e0.addr);
                chk("data0", int'(data0), e0.data);
                chk("isread0", int'(rd0), e0.rd);
            end
        end
    end

    always @(negedge clk) begin
        if (rst_n && (rdy1 || ec1 || ep1)) begin
            chk("excl1", int'(rdy1) + int'(ec1) + int'(ep1), 1);
            if (q1.size() == 0) begin
                chk("unexpected_pulse1", 1, 0);
            end else begin
                e1 = q1.pop_front();
                chk("kind1", rdy1 ? 0 : (ec1 ? 1 : 2), e1.kind);
                chk("latency1", cyc, e1.cyc);
                chk("cmd1", int'(cmd1), e1.cmd);
                chk("addr1", int'(addr1), e1.addr);
                chk("data1", int'(data1), e1.data);
                chk("isread1", int'(rd1), e1.rd);
            end
        end
    end

    initial begin
        #500us;
        $display("FAIL watchdog: simulation did not complete (t=%0t)", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < 2; i++) begin
            m_cmd[i] = 0; m_addr[i] = 0; m_data[i] = 0; m_rd[i] = 0;
        end
        repeat (3) @(posedge clk);
        #2;
        chk("reset_busy0", int'(busy0), 0);
        chk("reset_outs0", int'(cmd0) + int'(addr0) + int'(data0) + int'(rd0), 0);
        chk("reset_pulses0", int'(rdy0) + int'(ec0) + int'(ep0), 0);
        chk("reset_busy1", int'(busy1), 0);
        @(posedge clk);
        #1 rst_n = 1'b1;

        // Directed frames on the default instance
        send(0, 6, 'h1D, 'h39, 1'b0, 0);
        send(0, 5, 'h03, 'h00, 1'b0, 0);
        send(0, 7, 'h15, 'h55, 1'b0, 0);
        send(0, 5, 'h2A, 'h00, 1'b0, 0);
        send(0, 6, 'h11, 'hA5, 1'b1, 0);
        send(0, 5, 'h3F, 'h00, 1'b1, 0);

        // Reset asserted mid-way through the address field
        drive(0, 1'b1, 1'b1);
        drive(0, 1'b1, 1'b1);
        drive(0, 1'b1, 1'b1);
        drive(0, 1'b1, 1'b0);
        drive(0, 1'b1, 1'b0);
        drive(0, 1'b1, 1'b1);
        drive(0, 1'b1, 1'b1);
        chk("busy_mid_frame0", int'(busy0), 1);
        bv0 = 1'b0;
        #1 rst_n = 1'b0;
        #1;
        chk("rst_busy0", int'(busy0), 0);
        chk("rst_cmd0", int'(cmd0), 0);
        chk("rst_addr0", int'(addr0), 0);
        chk("rst_data0", int'(data0), 0);
        chk("rst_isread0", int'(rd0), 0);
        chk("rst_data1", int'(data1), 0);
        for (int i = 0; i < 2; i++) begin
            m_cmd[i] = 0; m_addr[i] = 0; m_data[i] = 0; m_rd[i] = 0;
        end
        #3 rst_n = 1'b1;
        @(posedge clk);
        #1;
        drive(0, 1'b1, 1'b0);
        send(0, 6, 'h2C, 'hC3, 1'b0, 0);
        send(0, 5, 'h07, 'h00, 1'b0, 30);

        // Randomly gapped traffic on both instances
        for (int n = 0; n < 14; n++) begin
            int c;
            c = (n % 3 == 2) ? int'($urandom_range(7)) : ((n % 2 == 0) ? 6 : 5);
            send(0, c, int'($urandom), int'($urandom), ($urandom_range(5) == 0), 50);
        end
        for (int n = 0; n < 14; n++) begin
            int c;
            c = (n % 3 == 2) ? int'($urandom_range(7)) : ((n % 2 == 0) ? 6 : 5);
            send(1, c, int'($urandom), int'($urandom), 1'b0, 50);
        end
        send(1, 6, 'hA, 'hBEEF, 1'b0, 0);
        send(1, 5, 'h5, 'h0, 1'b0, 0);

        repeat (4) @(posedge clk);
        #1;
        chk("pending_q0", q0.size(), 0);
        chk("pending_q1", q1.size(), 0);
        chk("idle_busy0", int'(busy0), 0);
        chk("idle_busy1", int'(busy1), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
